// File: rtl/noc_dfd_pkg.sv
// Shared definitions for the NoC debug-for-design trace path.
package noc_dfd_pkg;

    localparam int TRACE_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } trc_state_e;

    // Ceiling log2, usable in parameter defaults.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace buffer: synchronous write, registered read, no storage reset.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 32,
    parameter int AW    = noc_dfd_pkg::log2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    // Read output holds its value when rd_en_i is low; the controller relies on that.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/noc_trace_ctrl.sv
// Trace-capture controller: circular capture until trigger plus post window,
// then oldest-first readout over valid/ready through a prefetching output register.
module noc_trace_ctrl
    import noc_dfd_pkg::*;
#(
    parameter int TRACEw = TRACE_W_DEF,
    parameter int DEPTH  = 64,
    parameter int Dw     = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [Dw-1:0]     post_len,
    input  logic              trigger,
    input  logic [TRACEw-1:0] trace,
    output logic              armed,
    output logic              triggered,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [TRACEw-1:0] rd_data,
    output logic              rd_last,
    output logic [Dw-1:0]     trig_index
);

    trc_state_e        state_q, state_d;
    logic [Dw-1:0]     wr_ptr_q, wr_ptr_d;
    logic [Dw:0]       fill_q, fill_d;
    logic [Dw-1:0]     remain_q, remain_d;
    logic [Dw-1:0]     trig_addr_q, trig_addr_d;
    logic [Dw:0]       iss_cnt_q, iss_cnt_d;
    logic [Dw:0]       ld_cnt_q, ld_cnt_d;
    logic              ram_vld_q, ram_vld_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [TRACEw-1:0] rd_data_q, rd_data_d;

    logic              in_read, wr_en, hs, load, issue;
    logic [Dw-1:0]     start, rd_ptr;
    logic [TRACEw-1:0] ram_q;

    assign in_read = (state_q == ST_READ);
    // A full buffer has wrapped, so its oldest entry sits at the write pointer.
    assign start   = fill_q[Dw] ? wr_ptr_q : '0;
    assign rd_ptr  = start + iss_cnt_q[Dw-1:0];
    assign hs      = rd_valid_q & rd_ready;
    // ram_vld_q marks a prefetched word waiting in the RAM output register.
    assign load    = in_read & ram_vld_q & (~rd_valid_q | rd_ready);
    assign issue   = in_read & (iss_cnt_q < fill_q) & (~ram_vld_q | load);

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (TRACEw),
        .AW    (Dw)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (trace),
        .rd_en_i   (issue),
        .rd_addr_i (rd_ptr),
        .rd_data_o (ram_q)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        remain_d    = remain_q;
        trig_addr_d = trig_addr_q;
        iss_cnt_d   = iss_cnt_q;
        ld_cnt_d    = ld_cnt_q;
        ram_vld_d   = ram_vld_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;
        wr_en       = 1'b0;

        if (arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            fill_d     = '0;
            remain_d   = '0;
            iss_cnt_d  = '0;
            ld_cnt_d   = '0;
            ram_vld_d  = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + Dw'(1);
                    fill_d   = fill_q[Dw] ? fill_q : fill_q + (Dw+1)'(1);
                    if (trigger) begin
                        trig_addr_d = wr_ptr_q;
                        remain_d    = post_len;
                        state_d     = (post_len == '0) ? ST_READ : ST_POST;
                    end
                end
                ST_POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + Dw'(1);
                    fill_d   = fill_q[Dw] ? fill_q : fill_q + (Dw+1)'(1);
                    remain_d = remain_q - Dw'(1);
                    if (remain_q == Dw'(1)) state_d = ST_READ;
                end
                ST_READ: begin
                    if (issue) begin
                        iss_cnt_d = iss_cnt_q + (Dw+1)'(1);
                        ram_vld_d = 1'b1;
                    end else if (load) begin
                        ram_vld_d = 1'b0;
                    end
                    if (load) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = ram_q;
                        rd_last_d  = (ld_cnt_q == fill_q - (Dw+1)'(1));
                        ld_cnt_d   = ld_cnt_q + (Dw+1)'(1);
                    end else if (hs) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end
                    if (hs && rd_last_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            remain_q    <= '0;
            trig_addr_q <= '0;
            iss_cnt_q   <= '0;
            ld_cnt_q    <= '0;
            ram_vld_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            remain_q    <= remain_d;
            trig_addr_q <= trig_addr_d;
            iss_cnt_q   <= iss_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            ram_vld_q   <= ram_vld_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign armed      = (state_q == ST_ARMED);
    assign triggered  = (state_q == ST_POST);
    assign done       = in_read;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;
    assign trig_index = in_read ? (trig_addr_q - start) : '0;

endmodule

// File: tb/tb_noc_trace_ctrl.sv
// Directed bench for noc_trace_ctrl with DEPTH=8: table of capture/readout scenarios plus corner sequences.
module tb_noc_trace_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 3;
    localparam int TW    = 32;

    typedef struct {
        int post;
        int trig;
        int count;
        int first;
        int tidx;
        bit toggle;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] post_len = '0;
    logic [TW-1:0] trace = '0;
    logic          armed, triggered, done, rd_valid, rd_last;
    logic [TW-1:0] rd_data;
    logic [DW-1:0] trig_index;

    int checks = 0;
    int errors = 0;
    vec_t vt [4];

    always #5 clk = ~clk;

    noc_trace_ctrl #(
        .TRACEw (TW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .post_len   (post_len),
        .trigger    (trigger),
        .trace      (trace),
        .armed      (armed),
        .triggered  (triggered),
        .done       (done),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .trig_index (trig_index)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // Words base+0.. written one per cycle, trigger on word trig, ends after the final write.
    task automatic capture_words(input int post, input int trig, input int base);
        chk("armed_start", 32'(armed), 32'd1);
        for (int k = 0; k <= trig + post; k++) begin
            trace    = 32'(base + k);
            trigger  = (k == trig);
            post_len = DW'(post);
            step();
            if (k == trig && post != 0) chk("triggered", 32'(triggered), 32'd1);
        end
        trigger = 1'b0;
        chk("done_rise", 32'(done), 32'd1);
        chk("armed_off", 32'(armed), 32'd0);
    endtask

    task automatic read_words(input int count, input int first, input int tidx,
                              input bit toggle, input int maxw);
        int n = 0;
        int c = 0;
        logic stall = 1'b0;
        logic [TW-1:0] held = '0;
        logic [3:0] pat = 4'b1001;
        rd_ready = 1'b0;
        chk("rdv_lat0", 32'(rd_valid), 32'd0);
        step();
        chk("rdv_lat1", 32'(rd_valid), 32'd0);
        step();
        chk("rdv_lat2", 32'(rd_valid), 32'd1);
        chk("trig_index", 32'(trig_index), 32'(tidx));
        while (n < maxw && c < 100) begin
            rd_ready = toggle ? pat[c[1:0]] : 1'b1;
            if (stall) begin
                chk("stall_data", rd_data, held);
                chk("stall_valid", 32'(rd_valid), 32'd1);
            end
            if (rd_valid && rd_ready) begin
                chk("rd_data", rd_data, 32'(first + n));
                chk("rd_last", 32'(rd_last), 32'(n == count - 1));
                n++;
                stall = 1'b0;
            end else begin
                stall = rd_valid;
                held  = rd_data;
            end
            c++;
            step();
        end
        rd_ready = 1'b0;
        chk("words_read", 32'(n), 32'(maxw));
        if (!toggle) chk("no_bubble", 32'(c), 32'(maxw));
        if (maxw == count) begin
            chk("done_fall", 32'(done), 32'd0);
            chk("rdv_after", 32'(rd_valid), 32'd0);
        end
    endtask

    initial begin
        vt[0] = '{post: 3, trig: 2,  count: 6, first: 0,  tidx: 2, toggle: 1'b0};
        vt[1] = '{post: 2, trig: 15, count: 8, first: 10, tidx: 5, toggle: 1'b0};
        vt[2] = '{post: 0, trig: 9,  count: 8, first: 2,  tidx: 7, toggle: 1'b0};
        vt[3] = '{post: 3, trig: 2,  count: 6, first: 0,  tidx: 2, toggle: 1'b1};

        #12;
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_trig_index", 32'(trig_index), 32'd0);
        #5 reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            arm_pulse();
            capture_words(vt[i].post, vt[i].trig, 0);
            read_words(vt[i].count, vt[i].first, vt[i].tidx, vt[i].toggle, vt[i].count);
            step();
        end

        // Re-arm during readout after three words; arm wins over the pending handshake.
        arm_pulse();
        capture_words(3, 2, 0);
        read_words(6, 0, 2, 1'b0, 3);
        chk("pre_arm_valid", 32'(rd_valid), 32'd1);
        arm = 1'b1;
        rd_ready = 1'b1;
        step();
        arm = 1'b0;
        rd_ready = 1'b0;
        chk("rearm_rdv", 32'(rd_valid), 32'd0);
        chk("rearm_armed", 32'(armed), 32'd1);
        chk("rearm_done", 32'(done), 32'd0);
        capture_words(1, 1, 100);
        read_words(3, 100, 1, 1'b0, 3);
        step();

        // Async reset in the post window, then trigger without arm.
        arm_pulse();
        trigger = 1'b0; trace = 32'd50; post_len = DW'(4);
        step();
        trigger = 1'b1; trace = 32'd51;
        step();
        trigger = 1'b0; trace = 32'd52;
        chk("mid_triggered", 32'(triggered), 32'd1);
        step();
        #2 reset = 1'b0;
        #1;
        chk("arst_armed", 32'(armed), 32'd0);
        chk("arst_triggered", 32'(triggered), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_rd_last", 32'(rd_last), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_trig_index", 32'(trig_index), 32'd0);
        #3 reset = 1'b1;
        trigger = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("noarm_armed", 32'(armed), 32'd0);
            chk("noarm_triggered", 32'(triggered), 32'd0);
            chk("noarm_done", 32'(done), 32'd0);
        end
        trigger = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_trace_ctrl.md
# noc_trace_ctrl

Trace-capture controller for the NoC debug-for-design (DfD) path. It samples the network's 32-bit `trace` word every cycle into a circular buffer once armed. On `trigger` it stops after a programmable post-trigger window, then streams the captured window out oldest-first over a valid/ready port. It sits beside the NoC top, between its `trigger`/`trace` outputs and the host debug interface, and sequences the single trace buffer.

## Interface
- `TRACEw`, 32, trace word width (matches NoC `trace`)
- `DEPTH`, 64, buffer entries; power of two, ≥4
- `Dw`, log2(DEPTH), pointer width (derived)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset (one clock; polarity and synchronicity fixed)
- `arm`  in  1  single-cycle pulse: clear buffer, start capture
- `post_len`  in  Dw  words to capture after the trigger word; sampled on the trigger cycle
- `trigger`  in  1  NoC DfD trigger, level
- `trace`  in  TRACEw  NoC trace word
- `armed`  out  1  capturing, trigger not yet seen
- `triggered`  out  1  in post-trigger window
- `done`  out  1  capture complete, readout pending or in progress
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  consumer accepts word
- `rd_data`  out  TRACEw  captured word
- `rd_last`  out  1  qualifies final word of the window
- `trig_index`  out  Dw  readout position (0 = oldest) of the trigger word; stable while `done`

## Operation
- FSM states: IDLE, ARMED, POST, READ.
- IDLE: no writes. `arm` → ARMED, with `wr_ptr`=0 and `fill`=0.
- ARMED:
  - Each cycle, write `trace` at `wr_ptr`; `wr_ptr`++ mod DEPTH; `fill`++ saturating at DEPTH.
  - `trigger`=1 in ARMED: that cycle's word is the trigger word. Latch its address, load `remain`=`post_len`, go to POST.
- POST:
  - Write each cycle, `remain`--.
  - Transition to READ happens after the write made when `remain`==1.
  - `post_len`=0: trigger cycle goes straight to READ; the trigger word is the last word.
- READ:
  - Start address = (`fill`==DEPTH) ? `wr_ptr` : 0. Count = `fill`.
  - `trig_index` = (trig_addr − start) mod DEPTH.
  - Words are emitted oldest-first. `rd_last` is asserted with word count−1.
  - A handshake (`rd_valid`&&`rd_ready`) on the last word → IDLE.
- A post window larger than free space overwrites the oldest entries. The total captured is always ≤DEPTH, with the trigger word retained when `post_len`≤DEPTH−1.
- `arm` in any state aborts the current activity and restarts ARMED next cycle; no readout of the old data. `arm` takes priority over `trigger` and over a read handshake in the same cycle.
- `trigger` outside ARMED is ignored.

## Timing
- Reset (`reset`=0, async): state IDLE, pointers 0. `armed`, `triggered`, `done`, `rd_valid`, `rd_last`, `trig_index` = 0; `rd_data` = 0.
- `armed` is high the cycle after the `arm` pulse. `triggered` is high the cycle after the trigger sample. `done` is high the cycle after the final write.
- Read latency: RAM read is registered. The first `rd_valid` is 2 cycles after `done` rises.
- Words with `rd_ready` held high stream at 1 word/cycle, no bubbles. This uses a prefetch register that issues the next RAM read on each handshake.
- `rd_valid`, `rd_data` and `rd_last` hold stable while `rd_ready`=0.
- `done` deasserts the cycle after the last handshake.
- Reset asserted mid-capture or mid-read discards everything immediately.

## Structure
- Package `noc_dfd_pkg`: FSM state encoding, `TRACEw` default, and a `log2` function for `Dw`.
- Sub-module `trace_ram`: simple dual-port, DEPTH×TRACEw, synchronous write, registered read, no reset on storage.
- The controller holds the FSM, `wr_ptr`/`rd_ptr`/`fill`/`remain`, and the output skid register.

## Test plan
- DEPTH=8. Arm; `trace`=cycle count 0..; trigger on word 2; `post_len`=3 → 6 words 0..5, `trig_index`=2, `rd_last` on word 5.
- DEPTH=8. Arm; 20 words; trigger on word 15; `post_len`=2 → 8 words 10..17, `trig_index`=5.
- `post_len`=0; trigger on word 9 (after wrap) → last word is 9, `rd_last` with it, `trig_index`=7.
- Readout with `rd_ready` toggling 1,0,0,1 → no word lost or duplicated; `rd_data` stable while stalled.
- `arm` during READ after 3 words accepted → `rd_valid` drops the next cycle, `armed`=1, and the new capture reads from word 0.
- Async `reset` low mid-POST → all outputs 0 immediately; `trigger` after reset release without `arm` → no capture, stays IDLE.
